// File: rtl/music_pkg.sv
// Constants shared by the keypad front end and the tone generator.
// Note indices are bit positions in the one-hot note bus.
package music_pkg;

  localparam int unsigned NUM_NOTES = 7;
  localparam int unsigned CLK_HZ    = 25000000;

  localparam int unsigned N_DO  = 0;
  localparam int unsigned N_RE  = 1;
  localparam int unsigned N_MI  = 2;
  localparam int unsigned N_FA  = 3;
  localparam int unsigned N_SOL = 4;
  localparam int unsigned N_LA  = 5;
  localparam int unsigned N_SI  = 6;

  typedef logic [NUM_NOTES-1:0] note_t;

  // Keeps only the lowest set bit, so a chord resolves to its lowest note.
  function automatic note_t prio_onehot(input note_t pressed);
    return pressed & (~pressed + note_t'(1));
  endfunction

endpackage

// File: rtl/note_keypad_if.sv
// Button inputs and the clean control outputs that feed the tone generator.
// The keypad is the slave side; the board/testbench is the master side.
interface note_keypad_if;

  logic [music_pkg::NUM_NOTES-1:0] key_n;
  logic                            play_n;
  logic [music_pkg::NUM_NOTES-1:0] note;
  logic                            onoff;
  logic                            note_chg;

  modport master (
    output key_n,
    output play_n,
    input  note,
    input  onoff,
    input  note_chg
  );

  modport slave (
    input  key_n,
    input  play_n,
    output note,
    output onoff,
    output note_chg
  );

endinterface

// File: rtl/key_debounce.sv
// One button: 2-flop synchroniser, then a level is accepted only after
// DB_CYCLES consecutive cycles that disagree with the current stable level.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic level,
  output logic press
);

  localparam logic [23:0] CntMax = 24'(DB_CYCLES - 1);

  logic [1:0]  sync_q, sync_d;
  logic        st_q, st_d;
  logic [23:0] cnt_q, cnt_d;
  logic        press_q, press_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      st_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    sync_d = {sync_q[0], raw_n};
    st_d   = st_q;
    cnt_d  = cnt_q;
    if (sync_q[1] == st_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      st_d  = ~st_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 24'd1;
    end
    press_d = st_q & ~st_d;
  end

  assign level = st_q;
  assign press = press_q;

endmodule

// File: rtl/note_keypad.sv
// Keypad front end: debounced note keys resolved to a registered one-hot
// note, a play button that toggles onoff, and a pulse on every note change.
module note_keypad
  import music_pkg::*;
#(
  parameter int unsigned DB_CYCLES = CLK_HZ / 100
) (
  input  logic              clk,
  input  logic              rst_n,
  note_keypad_if.slave      kp
);

  note_t key_level;
  note_t key_press;
  logic  play_level;
  logic  play_press;

  note_t note_q, note_d;
  logic  onoff_q, onoff_d;
  logic  note_chg_q, note_chg_d;

  for (genvar i = 0; i < NUM_NOTES; i++) begin : g_key
    key_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_key_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_n (kp.key_n[i]),
      .level (key_level[i]),
      .press (key_press[i])
    );
  end

  key_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_play_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (kp.play_n),
    .level (play_level),
    .press (play_press)
  );

  // Note keys are level-driven; their press pulses are not needed here.
  logic unused_sig;
  assign unused_sig = ^{key_press, play_level};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_q     <= '0;
      onoff_q    <= 1'b0;
      note_chg_q <= 1'b0;
    end else begin
      note_q     <= note_d;
      onoff_q    <= onoff_d;
      note_chg_q <= note_chg_d;
    end
  end

  always_comb begin
    note_d     = prio_onehot(~key_level);
    onoff_d    = onoff_q ^ play_press;
    note_chg_d = (note_d != note_q);
  end

  assign kp.note     = note_q;
  assign kp.onoff    = onoff_q;
  assign kp.note_chg = note_chg_q;

endmodule

// File: tb/tb_note_keypad.sv
// Self-checking bench for note_keypad with DB_CYCLES = 4: exact-latency
// sequences, a vector table of settled states and a note-change scoreboard.
module tb_note_keypad;

  localparam int unsigned DB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  note_keypad_if kp ();

  note_keypad #(
    .DB_CYCLES (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  int total = 0;
  int bad = 0;

  logic [6:0] sb[$];
  logic [6:0] cur_note = 7'd0;
  logic       prev_chg = 1'b0;

  typedef struct {
    logic [6:0] key_n;
    logic       play_n;
    logic [6:0] exp_note;
    logic       exp_onoff;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Every change of the expected note must later show up as one note_chg pulse.
  task automatic expect_note(input logic [6:0] n);
    if (n != cur_note) begin
      sb.push_back(n);
      cur_note = n;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && kp.note_chg) begin
      if (sb.size() == 0) begin
        chk("chg_unexpected", 32'(kp.note_chg), 32'd0);
      end else begin
        chk("chg_note", 32'(kp.note), 32'(sb.pop_front()));
      end
      chk("chg_single", 32'(prev_chg), 32'd0);
    end
    prev_chg <= rst_n & kp.note_chg;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{7'b1111111, 1'b1, 7'b0000000, 1'b0};
    vecs[1]  = '{7'b1101111, 1'b1, 7'b0010000, 1'b0};
    vecs[2]  = '{7'b1111111, 1'b1, 7'b0000000, 1'b0};
    vecs[3]  = '{7'b1011111, 1'b1, 7'b0100000, 1'b0};
    vecs[4]  = '{7'b1011101, 1'b1, 7'b0000010, 1'b0};
    vecs[5]  = '{7'b1011111, 1'b1, 7'b0100000, 1'b0};
    vecs[6]  = '{7'b0000000, 1'b1, 7'b0000001, 1'b0};
    vecs[7]  = '{7'b0111111, 1'b1, 7'b1000000, 1'b0};
    vecs[8]  = '{7'b1111111, 1'b0, 7'b0000000, 1'b1};
    vecs[9]  = '{7'b1111111, 1'b1, 7'b0000000, 1'b1};
    vecs[10] = '{7'b0110111, 1'b0, 7'b0001000, 1'b0};
    vecs[11] = '{7'b1111111, 1'b1, 7'b0000000, 1'b0};

    kp.key_n  = 7'h7f;
    kp.play_n = 1'b1;
    #1;
    chk("rst_note", 32'(kp.note), 32'd0);
    chk("rst_onoff", 32'(kp.onoff), 32'd0);
    chk("rst_chg", 32'(kp.note_chg), 32'd0);
    step(3);
    rst_n = 1'b1;
    step(3);
    chk("idle_note", 32'(kp.note), 32'd0);

    // Single key: exact latency of press and release.
    expect_note(7'b0010000);
    kp.key_n = 7'b1101111;
    step(6);
    chk("sk_note_e6", 32'(kp.note), 32'd0);
    step(1);
    chk("sk_note_e7", 32'(kp.note), 32'b0010000);
    chk("sk_chg_e7", 32'(kp.note_chg), 32'd1);
    step(1);
    chk("sk_chg_e8", 32'(kp.note_chg), 32'd0);
    step(2);
    expect_note(7'b0000000);
    kp.key_n = 7'h7f;
    step(6);
    chk("rel_note_e6", 32'(kp.note), 32'b0010000);
    step(1);
    chk("rel_note_e7", 32'(kp.note), 32'd0);
    chk("rel_chg_e7", 32'(kp.note_chg), 32'd1);
    step(3);

    // Bounce: 3 low / 2 high never reaches the debounced level.
    for (int r = 0; r < 5; r++) begin
      kp.key_n = 7'b1111110;
      step(3);
      kp.key_n = 7'h7f;
      step(2);
      chk("bounce_note", 32'(kp.note), 32'd0);
    end
    step(6);
    chk("bounce_final", 32'(kp.note), 32'd0);

    // Settled states: chords, priority, play toggling alongside note changes.
    for (int v = 0; v < 12; v++) begin
      expect_note(vecs[v].exp_note);
      kp.key_n  = vecs[v].key_n;
      kp.play_n = vecs[v].play_n;
      step(10);
      chk($sformatf("vec%0d_note", v), 32'(kp.note), 32'(vecs[v].exp_note));
      chk($sformatf("vec%0d_onoff", v), 32'(kp.onoff), 32'(vecs[v].exp_onoff));
    end

    // Play held 20 cycles toggles once, release does nothing, next press toggles back.
    kp.play_n = 1'b0;
    step(6);
    chk("play_e6", 32'(kp.onoff), 32'd0);
    step(1);
    chk("play_e7", 32'(kp.onoff), 32'd1);
    step(13);
    chk("play_held", 32'(kp.onoff), 32'd1);
    kp.play_n = 1'b1;
    step(10);
    chk("play_release", 32'(kp.onoff), 32'd1);
    kp.play_n = 1'b0;
    step(10);
    chk("play_second", 32'(kp.onoff), 32'd0);
    kp.play_n = 1'b1;
    step(10);

    // Reset mid-run with onoff=1 and note=0000100, inputs kept held.
    expect_note(7'b0000100);
    kp.key_n  = 7'b1111011;
    kp.play_n = 1'b0;
    step(10);
    chk("pre_rst_note", 32'(kp.note), 32'b0000100);
    chk("pre_rst_onoff", 32'(kp.onoff), 32'd1);
    #2;
    rst_n = 1'b0;
    cur_note = 7'd0;
    #1;
    chk("async_rst_note", 32'(kp.note), 32'd0);
    chk("async_rst_onoff", 32'(kp.onoff), 32'd0);
    chk("async_rst_chg", 32'(kp.note_chg), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_note(7'b0000100);
    step(6);
    chk("held_note_e6", 32'(kp.note), 32'd0);
    chk("held_onoff_e6", 32'(kp.onoff), 32'd0);
    step(1);
    chk("held_note_e7", 32'(kp.note), 32'b0000100);
    chk("held_onoff_e7", 32'(kp.onoff), 32'd1);
    chk("held_chg_e7", 32'(kp.note_chg), 32'd1);
    step(1);
    chk("held_chg_e8", 32'(kp.note_chg), 32'd0);
    step(2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
